fpu_fetch_sequencer: RTL and testbench

FPU_FETCH_SEQUENCER -- requirements
Module: fpu_fetch_sequencer

---
 rtl/fpu_seq_pkg.sv | 15 +
 rtl/fpu_seq_wdt.sv | 34 +++
 rtl/fpu_fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fpu_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU fetch sequencer: FSM state encoding and
// default values for the PC increment and the restart instruction.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } seq_state_e;

  localparam int unsigned  DEFAULT_PC_STEP       = 4;
  localparam logic [31:0]  DEFAULT_RESTART_INSTR = 32'h0000_0010;

endpackage

// File: rtl/fpu_seq_wdt.sv
// Watchdog for the WAIT state of the fetch sequencer.
//   clk, rst_l : clock, asynchronous active-low reset
//   load       : clears the count (held high outside WAIT, so every WAIT
//                entry starts from zero)
//   count_en   : advance the count by one per cycle
//   expire     : high during the LIMIT-th counted cycle
module fpu_seq_wdt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_l,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // First counted cycle sees cnt==0, so the LIMIT-th cycle sees LIMIT-1.
  assign expire = count_en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fpu_fetch_sequencer.sv
// Instruction fetch/issue sequencer for the FPU.
// Fetches from PC, issues each instruction as a one-cycle strobe, waits for
// multi-cycle operations to finish, and restarts at PC 0 on RESTART_INSTR.
// Optional build macro FPU_SEQ_WDT_EN adds a WAIT-state watchdog.
// Ports:
//   clk, rst_l              : clock, asynchronous active-low reset
//   start                   : keep fetching while high
//   flush                   : synchronous abort to IDLE, PC 0
//   mem_req, mem_addr       : fetch request (held until mem_rvalid), address
//   mem_rvalid, mem_rdata   : fetch response
//   multi_cycle, exec_done  : decoder flag in ISSUE, execution-complete
//   instr_out, instr_valid  : issued instruction and its one-cycle strobe
//   busy                    : any state other than IDLE
//   timeout                 : watchdog expiry pulse (0 without the macro)
module fpu_fetch_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned          PC_W          = 32,
  parameter int unsigned          INSTR_W       = 32,
  parameter int unsigned          PC_STEP       = DEFAULT_PC_STEP,
  parameter logic [INSTR_W-1:0]   RESTART_INSTR = INSTR_W'(DEFAULT_RESTART_INSTR),
  parameter int unsigned          WDT_CYCLES    = 64
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               start,
  input  logic               flush,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               multi_cycle,
  input  logic               exec_done,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               busy,
  output logic               timeout
);

  seq_state_e         state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr_q;
  logic               wdt_expire;

`ifdef FPU_SEQ_WDT_EN
  fpu_seq_wdt #(
    .LIMIT (WDT_CYCLES)
  ) u_wdt (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (state != S_WAIT),
    .count_en (state == S_WAIT),
    .expire   (wdt_expire)
  );

  // exec_done arriving in the expiry cycle wins over the watchdog.
  assign timeout = wdt_expire && !exec_done && !flush;
`else
  assign wdt_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_rvalid) begin
            instr_q <= mem_rdata;
            pc      <= pc + PC_W'(PC_STEP);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_q == RESTART_INSTR) begin
            pc    <= '0;
            state <= S_IDLE;
          end else if (multi_cycle) begin
            state <= S_WAIT;
          end else begin
            state <= start ? S_FETCH : S_IDLE;
          end
        end
        S_WAIT: begin
          if (exec_done)       state <= start ? S_FETCH : S_IDLE;
          else if (wdt_expire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state; reset drops them at once.
  assign busy        = (state != S_IDLE);
  assign mem_req     = (state == S_FETCH);
  assign mem_addr    = pc;
  assign instr_valid = (state == S_ISSUE);
  assign instr_out   = instr_valid ? instr_q : '0;

endmodule

// File: tb/tb_fpu_fetch_sequencer.sv
// Self-checking bench for fpu_fetch_sequencer: a memory/execution driver
// issues randomized transactions and pushes expected issues into a
// scoreboard; a separate monitor pops and compares on every instr_valid.
module tb_fpu_fetch_sequencer;

  localparam int unsigned PCW     = 8;
  localparam int unsigned PC_MOD  = 1 << PCW;
  localparam int unsigned STEP    = 4;
  localparam logic [31:0] RESTART = 32'h0000_0010;
  localparam int unsigned WDT     = 64;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             start;
  logic             flush;
  logic             mem_req;
  logic [PCW-1:0]   mem_addr;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             multi_cycle;
  logic             exec_done;
  logic [31:0]      instr_out;
  logic             instr_valid;
  logic             busy;
  logic             timeout;

  fpu_fetch_sequencer #(
    .PC_W          (PCW),
    .INSTR_W       (32),
    .PC_STEP       (STEP),
    .RESTART_INSTR (RESTART),
    .WDT_CYCLES    (WDT)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .start       (start),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .multi_cycle (multi_cycle),
    .exec_done   (exec_done),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every issue must match the oldest expected fetch, one cycle
  // after its mem_rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", {32'h0, instr_out}, 64'hdead_0000_0000_0000);
      end else begin
        e = sb.pop_front();
        chk("issue_data", instr_out, e.data);
        chk("issue_cycle", cyc, e.at_cyc);
      end
    end else begin
      chk("instr_out_zero", instr_out, 0);
    end
`ifndef FPU_SEQ_WDT_EN
    chk("timeout_low", timeout, 0);
`endif
  end

  // Precondition: at a negedge with the sequencer fetching and start=1.
  task automatic run_instr(input logic [31:0] d, input int lat, input bit mc,
                           input int w, input bit fl, input bit drop_start);
    bit   idle_now;
    bit   timed_out;
    exp_t e;
    timed_out = 1'b0;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, model_pc);
    chk("fetch_busy", busy, 1);
    for (int i = 0; i < lat; i++) begin
      exec_done = ($urandom_range(0, 3) == 0);
      tick();
      chk("hold_req", mem_req, 1);
      chk("hold_addr", mem_addr, model_pc);
    end
    exec_done  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    flush      = fl;
    if (drop_start) start = 1'b0;
    if (!fl) begin
      e.data   = d;
      e.at_cyc = cyc + 1;
      sb.push_back(e);
    end
    tick();
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    mem_rdata  = $urandom;
    if (fl) begin
      model_pc = 0;
      idle_now = 1'b1;
    end else begin
      model_pc    = (model_pc + STEP) % PC_MOD;
      multi_cycle = mc;
      tick();
      multi_cycle = 1'b0;
      if (d == RESTART) begin
        model_pc = 0;
        idle_now = 1'b1;
      end else if (mc) begin
        for (int i = 0; i <= w; i++) begin
          chk("wait_busy", busy, 1);
          chk("wait_no_req", mem_req, 0);
`ifdef FPU_SEQ_WDT_EN
          if (i == WDT - 1) begin
            chk("wdt_timeout", timeout, 1);
            timed_out = 1'b1;
            break;
          end
`endif
          if (i < w) tick();
        end
        if (timed_out) begin
          tick();
        end else begin
          exec_done = 1'b1;
          tick();
          exec_done = 1'b0;
        end
        idle_now = timed_out || !start;
      end else begin
        idle_now = !start;
      end
    end
    if (idle_now) begin
      chk("idle_busy", busy, 0);
      chk("idle_no_req", mem_req, 0);
      chk("idle_pc", mem_addr, model_pc);
      if (!start) begin
        tick();
        chk("idle_hold", busy, 0);
        start = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    rst_l = 1'b0; start = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; multi_cycle = 1'b0; exec_done = 1'b0;
    repeat (2) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pc", mem_addr, 0);
    rst_l = 1'b1;
    tick();
    chk("idle_no_start", busy, 0);
    start = 1'b1;
    tick();

    // Zero-wait stream: addresses 0,4,8, issue every second cycle.
    for (int i = 0; i < 3; i++) run_instr($urandom, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("pc_after_3", mem_addr, 12);
    // Slow memory, spurious exec_done while fetching.
    run_instr(32'hcafe_0001, 5, 1'b0, 0, 1'b0, 1'b0);
    // Multi-cycle op finishing after 10 WAIT cycles.
    run_instr(32'hcafe_0002, 1, 1'b1, 10, 1'b0, 1'b0);
    // Restart instruction with start held.
    run_instr(RESTART, 0, 1'b0, 0, 1'b0, 1'b0);
    // Flush coinciding with mem_rvalid at PC 8.
    run_instr(32'h1111_0000, 0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(32'h1111_0004, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("flush_at_8", mem_addr, 8);
    run_instr(32'h1111_0008, 0, 1'b0, 0, 1'b1, 1'b0);
    // Long wait: WAIT must hold (or the watchdog fires when built in).
    run_instr(32'h2222_0000, 0, 1'b1, 70, 1'b0, 1'b0);
    // Stream long enough to wrap the 8-bit PC.
    for (int i = 0; i < 70; i++) run_instr($urandom | 32'h100, 0, 1'b0, 0, 1'b0, 1'b0);

    // Reset mid-fetch, then a late mem_rvalid in IDLE.
    chk("pre_reset_req", mem_req, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_busy", busy, 0);
    start = 1'b0;
    tick();
    rst_l = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h3333_3333;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_idle", busy, 0);
    chk("late_rvalid_pc", mem_addr, 0);
    model_pc = 0;
    start = 1'b1;
    tick();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? RESTART : ($urandom | 32'h100);
      run_instr(d, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 6), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0));
    end

    start = 1'b0;
    repeat (4) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
